// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples sck/ws/sd in the clk domain, deserialises
// MSB-first left/right words and presents each stereo pair on a valid/ack handshake.
module i2s_slave_rx #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              sck,
  input  logic              ws,
  input  logic              sd,
  output logic [DATA_W-1:0] data_left,
  output logic [DATA_W-1:0] data_right,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_sr, ws_sr, sd_sr;
  logic                   sck_s, ws_s, sd_s;
  logic                   sck_prev, ws_prev;
  logic                   rise, bnd;
  logic [CW-1:0]          cnt, cnt_inc;
  logic [DATA_W-1:0]      acc, word, mask, left_hold;
  logic                   left_ok, word_ok;
  logic                   cap_left, emit, bad;

  assign sck_s = sck_sr[SYNC_STAGES-1];
  assign ws_s  = ws_sr[SYNC_STAGES-1];
  assign sd_s  = sd_sr[SYNC_STAGES-1];

  assign rise = sck_s & ~sck_prev;
  assign bnd  = rise & (ws_s ^ ws_prev);

  // Shifting the MSB mask past the word width drops excess bits for free.
  assign mask    = MSB >> cnt;
  assign word    = sd_s ? (acc | mask) : acc;
  assign word_ok = (cnt == CW'(DATA_W - 1));
  assign cnt_inc = (cnt == CW'(DATA_W + 1)) ? cnt : cnt + CW'(1);

  assign cap_left = enable && (state == RUN) && bnd && !ws_prev;
  assign emit     = enable && (state == RUN) && bnd && ws_prev && left_ok;
  assign bad      = enable && (state == RUN) && bnd && !word_ok;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = SYNC;
        SYNC:    if (bnd) state_nx = RUN;
        RUN:     state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_sr     <= '0;
      ws_sr      <= '0;
      sd_sr      <= '0;
      sck_prev   <= 1'b0;
      ws_prev    <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      left_hold  <= '0;
      left_ok    <= 1'b0;
      data_left  <= '0;
      data_right <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
      ws_sr    <= {ws_sr[SYNC_STAGES-2:0], ws};
      sd_sr    <= {sd_sr[SYNC_STAGES-2:0], sd};
      sck_prev <= sck_s;
      if (rise) ws_prev <= ws_s;
      if (!enable || state == IDLE) begin
        cnt       <= '0;
        acc       <= '0;
        left_hold <= '0;
        left_ok   <= 1'b0;
        rx_valid  <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (rise) begin
          if (bnd) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= word;
            cnt <= cnt_inc;
          end
        end
        if (cap_left) begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end
        if (emit) begin
          data_left  <= left_hold;
          data_right <= word;
          left_ok    <= 1'b0;
        end
        if (bad) frame_err <= 1'b1;
        if (emit)        rx_valid <= 1'b1;
        else if (rx_ack) rx_valid <= 1'b0;
        // An ack landing with the new pair hands over cleanly, no overrun.
        if (emit && rx_valid && !rx_ack) overrun <= 1'b1;
      end
    end
  end
endmodule

// File: doc/i2s_slave_rx.md
Name: i2s_slave_rx

Overview:
- I2S slave receiver. Accepts an externally generated bit clock (sck), word select (ws) and serial data (sd), and oversamples them in the system clock domain.
- Deserialises MSB-first words for the left channel (ws=0) and right channel (ws=1).
- Presents each completed stereo pair on a valid/ack handshake toward the APB register block.
- Counterpart of the I2S master transmitter; sits on the receive side of the audio peripheral.

Parameters:
- DATA_W, 32, bits per channel word delivered on data_left/data_right.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser for sck, ws and sd (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the sck frequency.
- nrst  input  1  asynchronous active-low reset.
- enable  input  1  receiver enable; low holds the block in IDLE and clears state.
- sck  input  1  I2S bit clock, asynchronous to clk.
- ws  input  1  I2S word select, asynchronous; 0=left, 1=right.
- sd  input  1  I2S serial data, asynchronous; changes on the falling edge of sck.
- data_left  output  DATA_W  last completed left word.
- data_right  output  DATA_W  last completed right word.
- rx_valid  output  1  a stereo pair is available; held until acknowledged.
- rx_ack  input  1  consumer acknowledge; single-cycle pulse.
- overrun  output  1  sticky: a pair was overwritten while rx_valid was high.
- frame_err  output  1  sticky: a word had a bit count different from DATA_W.

Behaviour:
- Reset: all outputs 0; synchronisers, shift register and counters cleared; FSM in IDLE.
- Input path: sck, ws and sd each pass through SYNC_STAGES flops, so all three carry the same delay.
- Edge detect: a rising edge is a synced sck of 1 whose previous registered value was 0. All sampling occurs only in the edge cycle E, using synced ws/sd.
- At every rising edge: ws_prev <= ws_s.
- Word boundary: ws_s != ws_prev at edge E.
  - The sd sample at E is the final (LSB-position) bit of the word belonging to ws_prev.
  - The next edge carries the MSB of the new word.
- Bit placement:
  - A per-word counter cnt starts at 0 after each boundary.
  - Each edge writes sd to bit DATA_W-1-cnt while cnt < DATA_W; bits beyond DATA_W are dropped.
  - Missing LSBs read as 0.
  - The accumulator is cleared at each boundary.
  - cnt saturates at DATA_W+1.
- Word length check: the completed word's count includes the boundary-edge sample. If the count != DATA_W, set frame_err (in RUN only).
- FSM:
  - IDLE: enable=0; counters and accumulator cleared. enable=1 moves to SYNC.
  - SYNC: wait for the first boundary; the partial word is discarded with no frame_err. At that boundary go to RUN, then begin accumulating the new word.
  - RUN:
    - A boundary with ws_prev=0 latches the completed word into a left holding register.
    - A boundary with ws_prev=1 loads data_left <= left holding register and data_right <= completed word, and sets rx_valid.
    - A pair is emitted only after its left word was captured in RUN (the first right word after SYNC is discarded).
  - enable=0 from any state goes to IDLE next cycle and clears rx_valid, overrun, frame_err and the holding registers. data_left/data_right keep their values.
- Latency: rx_valid rises in cycle E+1, where E is the cycle in which the right-word boundary edge is detected. That is SYNC_STAGES+2 clk cycles after the sck rising edge at the pin.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid next cycle.
  - rx_ack while rx_valid=0 is ignored.
- Overrun:
  - A new pair while rx_valid=1 and rx_ack=0 overwrites the data, keeps rx_valid=1 and sets overrun.
  - A new pair in the same cycle as rx_ack leaves rx_valid=1 with the new data and does not set overrun.
- Sticky flags clear only via reset or enable=0.
- ws toggling with no sck edges has no effect; only edge-qualified samples count.

Test Plan:
- Reset: assert nrst=0 mid-stream -> all outputs 0 immediately; after release with enable=1, the first partial frame is discarded and rx_valid stays 0 until one full left+right pair is received.
- Normal: fclk=8*fsck, frames L=0xA5A51234 / R=0x0F0FF0F0 -> rx_valid rises E+1 after the right-word boundary; data match; frame_err=0. rx_ack clears rx_valid next cycle.
- Overrun: send pairs (0x11111111, 0x22222222) then (0x33333333, 0x44444444) with no ack -> overrun=1, rx_valid=1, data = second pair.
- Short/long words: 24-bit words L=0xABCDEF -> data_left=0xABCDEF00, frame_err=1. 34-bit words -> first 32 bits kept, frame_err=1.
- Simultaneous events: rx_ack in the same cycle as a new pair completion -> rx_valid stays 1 with the new data, overrun stays 0.
- Enable drop mid-word: enable=0 during a right word -> rx_valid, overrun and frame_err go to 0 next cycle. Re-enable -> SYNC again, and the first frame is not reported.
